// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared widths, sample type and quarter-wave sine ROM for nco_voice
package nco_pkg;

   localparam int LUT_BITS   = 8;
   localparam int FRAC_BITS  = 16;
   localparam int PHASE_BITS = 32;

   typedef logic signed [15:0] sample_t;

   // round(32767*sin(2*pi*k/256)) for k = 0..64; the other three quadrants are folded from it
   localparam sample_t QUARTER_SINE [0:64] = '{
      16'sd0,     16'sd804,   16'sd1608,  16'sd2410,  16'sd3212,  16'sd4011,  16'sd4808,  16'sd5602,
      16'sd6393,  16'sd7179,  16'sd7962,  16'sd8739,  16'sd9512,  16'sd10278, 16'sd11039, 16'sd11793,
      16'sd12539, 16'sd13279, 16'sd14010, 16'sd14732, 16'sd15446, 16'sd16151, 16'sd16846, 16'sd17530,
      16'sd18204, 16'sd18868, 16'sd19519, 16'sd20159, 16'sd20787, 16'sd21403, 16'sd22005, 16'sd22594,
      16'sd23170, 16'sd23731, 16'sd24279, 16'sd24811, 16'sd25329, 16'sd25832, 16'sd26319, 16'sd26790,
      16'sd27245, 16'sd27683, 16'sd28105, 16'sd28510, 16'sd28898, 16'sd29268, 16'sd29621, 16'sd29956,
      16'sd30273, 16'sd30571, 16'sd30852, 16'sd31113, 16'sd31356, 16'sd31580, 16'sd31785, 16'sd31971,
      16'sd32137, 16'sd32285, 16'sd32412, 16'sd32521, 16'sd32609, 16'sd32678, 16'sd32728, 16'sd32757,
      16'sd32767
   };

   function automatic sample_t sine_lut(input logic [LUT_BITS-1:0] idx);
      logic [6:0] k;
      sample_t    mag;
      k   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
      mag = QUARTER_SINE[k];
      return idx[7] ? -mag : mag;
   endfunction

endpackage

// File: rtl/nco_voice_if.sv
// rtl/nco_voice_if.sv - control and sample bundle between the NCO voice and its user
interface nco_voice_if;
   import nco_pkg::*;

   logic                    nco_mute;
   logic [PHASE_BITS-1:0]   accumulator_increment_value;
   logic                    sample_clk_en;
   logic                    bit_clk_en;
   sample_t                 sample_output;
   logic signed [PHASE_BITS-1:0] accumulator_value;
   sample_t                 sample_li_offset;

   modport master (
      output nco_mute, accumulator_increment_value,
      input  sample_clk_en, bit_clk_en, sample_output, accumulator_value, sample_li_offset
   );

   modport slave (
      input  nco_mute, accumulator_increment_value,
      output sample_clk_en, bit_clk_en, sample_output, accumulator_value, sample_li_offset
   );

endinterface

// File: rtl/nco_voice_clk_div.sv
// rtl/nco_voice_clk_div.sv - master clock divider producing sample and bit strobes
module clk_div #(
   parameter int SAMPLE_DIV = 512,
   parameter int BIT_DIV    = 8
) (
   input  logic master_clk,
   input  logic rst,
   output logic sample_clk_en,
   output logic bit_clk_en
);

   localparam int CNT_W = 9;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge master_clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(SAMPLE_DIV - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // both strobes decode the same counter, so the last bit of a frame lands on the sample strobe
   assign sample_clk_en = (cnt == CNT_W'(SAMPLE_DIV - 1));
   assign bit_clk_en    = ((int'(cnt) % BIT_DIV) == (BIT_DIV - 1));

endmodule

// File: rtl/nco_voice.sv
// rtl/nco_voice.sv - single-voice phase accumulator with linearly interpolated sine lookup
module nco_voice
   import nco_pkg::*;
#(
   parameter int SAMPLE_DIV = 512,
   parameter int BIT_DIV    = 8
) (
   input  logic        master_clk,
   input  logic        rst,
   nco_voice_if.slave  bus
);

   logic sample_clk_en;
   logic bit_clk_en;

   clk_div #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .BIT_DIV    (BIT_DIV)
   ) u_clk_div (
      .master_clk    (master_clk),
      .rst           (rst),
      .sample_clk_en (sample_clk_en),
      .bit_clk_en    (bit_clk_en)
   );

   logic [PHASE_BITS-1:0] acc;
   sample_t               sample_q;
   sample_t               off_q;

   logic [LUT_BITS-1:0]   idx;
   logic [LUT_BITS-1:0]   idx_nxt;
   logic [FRAC_BITS-1:0]  frac;
   sample_t               cur;
   sample_t               nxt;
   sample_t               off;
   sample_t               sum;
   logic signed [16:0]    diff;
   logic signed [32:0]    prod;
   logic signed [17:0]    sum_wide;

   always_comb begin
      idx      = acc[PHASE_BITS-1 -: LUT_BITS];
      idx_nxt  = idx + LUT_BITS'(1);
      frac     = acc[PHASE_BITS-LUT_BITS-1 -: FRAC_BITS];
      cur      = sine_lut(idx);
      nxt      = sine_lut(idx_nxt);
      diff     = 17'(nxt) - 17'(cur);
      prod     = 33'(diff) * 33'($signed({1'b0, frac}));
      // bits [31:16] are the arithmetic >>>16 truncated to 16 bits, i.e. floor toward -inf
      off      = prod[31:16];
      sum_wide = 18'(cur) + 18'(off);
      if (sum_wide > 18'sd32767) begin
         sum = 16'sh7fff;
      end else if (sum_wide < -18'sd32768) begin
         sum = 16'sh8000;
      end else begin
         sum = sum_wide[15:0];
      end
   end

   // accumulator advances even when muted so the phase stays continuous
   always_ff @(posedge master_clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         sample_q <= '0;
         off_q    <= '0;
      end else if (sample_clk_en) begin
         acc      <= acc + bus.accumulator_increment_value;
         sample_q <= bus.nco_mute ? '0 : sum;
         off_q    <= off;
      end
   end

   assign bus.sample_clk_en     = sample_clk_en;
   assign bus.bit_clk_en        = bit_clk_en;
   assign bus.sample_output     = sample_q;
   assign bus.accumulator_value = $signed(acc);
   assign bus.sample_li_offset  = off_q;

endmodule

// File: tb/tb_nco_voice.sv
// tb/tb_nco_voice.sv - scoreboard bench for nco_voice with directed phase/increment vectors
module tb_nco_voice;
   import nco_pkg::*;

   logic master_clk = 1'b0;
   logic rst        = 1'b0;

   always #5 master_clk = ~master_clk;

   nco_voice_if bus ();

   nco_voice u_dut (
      .master_clk (master_clk),
      .rst        (rst),
      .bus        (bus)
   );

   typedef struct {
      string       tag;
      int          smp;
      int          off;
      logic [31:0] acc;
      bit          cs;
      bit          co;
      bit          ca;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   int          c_smp [0:10] = '{0, 402, 804, 1206, 1608, 2009, 2410, 2811, 32742, 402, -32703};
   int          c_off [0:10] = '{0, 402, 0, 402, 0, 401, 0, 401, -15, -402, -25};
   logic [31:0] c_acc [0:10] = '{32'h0080_0000, 32'h0100_0000, 32'h0180_0000, 32'h0200_0000,
                                 32'h0280_0000, 32'h0300_0000, 32'h0380_0000, 32'h4180_0000,
                                 32'h7F80_0000, 32'hBD80_0000, 32'hFB80_0000};
   int          d_lut [0:9]  = '{0, 1608, 3212, 4808, 6393, 7962, 9512, 11039, 12539, 14010};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
                  name, $signed(act), act, $signed(exp), exp);
      end
   endtask

   task automatic push(input string tag, input int smp, input int off, input logic [31:0] acc,
                       input bit cs, input bit co, input bit ca);
      exp_t e;
      e.tag = tag; e.smp = smp; e.off = off; e.acc = acc;
      e.cs = cs; e.co = co; e.ca = ca;
      q.push_back(e);
   endtask

   task automatic wait_strobe(output int edges);
      edges = 0;
      do begin
         @(negedge master_clk);
         edges++;
      end while (!bus.sample_clk_en && edges < 1000);
      if (!bus.sample_clk_en) check("strobe_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_test(input logic [31:0] inc);
      @(negedge master_clk);
      rst = 1'b0;
      bus.nco_mute = 1'b0;
      bus.accumulator_increment_value = inc;
      repeat (2) @(negedge master_clk);
   endtask

   task automatic release_reset();
      @(negedge master_clk);
      rst = 1'b1;
   endtask

   task automatic drain(input string name);
      repeat (2) @(negedge master_clk);
      check(name, 32'(q.size()), 32'd0);
   endtask

   // monitor: a strobe seen at one negedge means fresh outputs by the next negedge
   initial begin : monitor
      exp_t e;
      bit   pend;
      pend = 1'b0;
      forever begin
         @(negedge master_clk);
         if (pend && q.size() > 0) begin
            e = q.pop_front();
            if (e.cs) check({e.tag, ".smp"}, 32'(bus.sample_output), e.smp);
            if (e.co) check({e.tag, ".off"}, 32'(bus.sample_li_offset), e.off);
            if (e.ca) check({e.tag, ".acc"}, bus.accumulator_value, e.acc);
         end
         pend = bus.sample_clk_en && rst;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int edges;
      int nsmp, first_at, last_at, bad_gap, nbit, bad_bit, bad_coin;
      int s;
      bit cs;
      logic [31:0] a;

      bus.nco_mute = 1'b0;
      bus.accumulator_increment_value = '0;
      repeat (3) @(negedge master_clk);
      check("rst.smp", 32'(bus.sample_output), 32'd0);
      check("rst.off", 32'(bus.sample_li_offset), 32'd0);
      check("rst.acc", bus.accumulator_value, 32'd0);
      check("rst.sen", 32'(bus.sample_clk_en), 32'd0);
      check("rst.ben", 32'(bus.bit_clk_en), 32'd0);

      // strobe rates
      release_reset();
      nsmp = 0; first_at = 0; last_at = 0; bad_gap = 0; nbit = 0; bad_bit = 0; bad_coin = 0;
      for (int i = 1; i <= 2048; i++) begin
         @(negedge master_clk);
         if (bus.sample_clk_en) begin
            if (nsmp == 0) first_at = i;
            else if (i - last_at != 512) bad_gap++;
            last_at = i;
            nsmp++;
            if (!bus.bit_clk_en) bad_coin++;
         end
         if (bus.bit_clk_en) begin
            nbit++;
            if (i % 8 != 7) bad_bit++;
         end
      end
      check("a.sample_pulses", 32'(nsmp), 32'd4);
      check("a.first_strobe", 32'(first_at), 32'd511);
      check("a.bad_gaps", 32'(bad_gap), 32'd0);
      check("a.bit_pulses", 32'(nbit), 32'd256);
      check("a.bad_bit_pos", 32'(bad_bit), 32'd0);
      check("a.not_coincident", 32'(bad_coin), 32'd0);

      // exact sine points, then a jump to idx 192 and back to 64
      start_test(32'h0200_0000);
      for (int n = 0; n < 35; n++) begin
         cs = 1'b1;
         case (n)
            0: s = 0;        1: s = 1608;    2: s = 3212;    3: s = 4808;
            4: s = 6393;     8: s = 12539;   16: s = 23170;  32: s = 32767;
            33: s = -32767;  34: s = 32767;
            default: begin s = 0; cs = 1'b0; end
         endcase
         a = (n < 32) ? 32'((n + 1) << 25) : ((n == 33) ? 32'h4000_0000 : 32'hC000_0000);
         push($sformatf("b%0d", n), s, 0, a, cs, 1'b1, 1'b1);
      end
      release_reset();
      for (int n = 0; n < 35; n++) begin
         wait_strobe(edges);
         if (n == 32) bus.accumulator_increment_value = 32'h8000_0000;
      end
      drain("b.drained");

      // interpolation, including negative differences that must floor
      start_test(32'h0080_0000);
      for (int n = 0; n <= 10; n++) push($sformatf("c%0d", n), c_smp[n], c_off[n], c_acc[n], 1'b1, 1'b1, 1'b1);
      release_reset();
      for (int n = 0; n <= 10; n++) begin
         wait_strobe(edges);
         if (n == 7) bus.accumulator_increment_value = 32'h3E00_0000;
      end
      drain("c.drained");

      // mute for samples 10..14, phase continues underneath
      start_test(32'h0200_0000);
      for (int n = 0; n <= 16; n++) begin
         s = (n < 10) ? d_lut[n] : (n < 15) ? 0 : (n == 15) ? 22005 : 23170;
         push($sformatf("d%0d", n), s, 0, 32'((n + 1) << 25), 1'b1, 1'b1, 1'b1);
      end
      release_reset();
      for (int n = 0; n <= 16; n++) begin
         wait_strobe(edges);
         if (n == 10) bus.nco_mute = 1'b1;
         if (n == 15) bus.nco_mute = 1'b0;
      end
      drain("d.drained");

      // 32-bit wrap, interpolation from idx 255 into idx 0, async reset mid-period
      start_test(32'hF000_0000);
      push("e0", 0, 0, 32'hF000_0000, 1'b1, 1'b1, 1'b1);
      push("e1", -12539, 0, 32'hFF80_0000, 1'b1, 1'b1, 1'b1);
      push("e2", -402, 402, 32'h0F00_0000, 1'b1, 1'b1, 1'b1);
      push("e3", 11793, 0, 32'h1E80_0000, 1'b1, 1'b1, 1'b1);
      release_reset();
      for (int n = 0; n <= 3; n++) begin
         wait_strobe(edges);
         if (n == 1) bus.accumulator_increment_value = 32'h0F80_0000;
      end
      repeat (100) @(negedge master_clk);
      #3 rst = 1'b0;
      #1;
      check("e.rst.smp", 32'(bus.sample_output), 32'd0);
      check("e.rst.off", 32'(bus.sample_li_offset), 32'd0);
      check("e.rst.acc", bus.accumulator_value, 32'd0);
      check("e.rst.sen", 32'(bus.sample_clk_en), 32'd0);
      check("e.rst.ben", 32'(bus.bit_clk_en), 32'd0);
      repeat (4) @(negedge master_clk);
      push("e.post0", 0, 0, 32'h0F80_0000, 1'b1, 1'b1, 1'b1);
      push("e.post1", 12166, 373, 32'h1F00_0000, 1'b1, 1'b1, 1'b1);
      release_reset();
      wait_strobe(edges);
      check("e.first_strobe", 32'(edges), 32'd511);
      wait_strobe(edges);
      drain("e.drained");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
